// File: rtl/pia_uart_pkg.sv
// Shared definitions for the Apple-1 PIA UART: register offsets, FSM state
// encodings and the optional lower-to-upper case helper.
package pia_uart_pkg;

  localparam logic [1:0] REG_KBD   = 2'd0;
  localparam logic [1:0] REG_KBDCR = 2'd1;
  localparam logic [1:0] REG_DSP   = 2'd2;
  localparam logic [1:0] REG_DSPCR = 2'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/pia_uart_if.sv
// CPU-side register bus of the PIA UART; the CPU is master, the UART is slave.
interface pia_uart_if;
  logic       enable;
  logic [1:0] address;
  logic       w_en;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output enable, output address, output w_en, output din, input dout);
  modport slave  (input enable, input address, input w_en, input din, output dout);
endinterface

// File: rtl/pia_uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling FSM and a
// one-cycle rx_valid pulse carrying each byte whose stop bit reads 1.
module pia_uart_rx #(
  parameter int unsigned CLK_FREQ = 25000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);
  import pia_uart_pkg::*;

  localparam int unsigned DIV  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  always_ff @(posedge clk25) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          // Re-check the start bit at its centre; a high line means a glitch.
          if (baud_cnt == CW'(HALF - 1)) begin
            baud_cnt <= '0;
            state    <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt == CW'(DIV - 1)) begin
            baud_cnt <= '0;
            shreg    <= {rx_sync, shreg[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt == CW'(DIV - 1)) begin
            baud_cnt <= '0;
            state    <= RX_IDLE;
            if (rx_sync) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pia_uart.sv
// Apple-1 PIA register model (KBD/KBDCR/DSP/DSPCR) bridged to an 8N1 UART.
// Optional macro PIA_UART_UPCASE_EN folds received a..z to A..Z.
module pia_uart #(
  parameter int unsigned CLK_FREQ = 25000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk25,
  input  logic       reset,
  pia_uart_if.slave  bus,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       uart_cts,
  output logic [7:0] led
);
  import pia_uart_pkg::*;

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);

  logic [7:0]    kbd_data;
  logic          kbd_ready;
  logic          tx_busy;
  logic [7:0]    rx_byte, rx_store;
  logic          rx_valid;
  logic          kbd_rd, dsp_wr;
  logic          din_unused;
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  pia_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk25    (clk25),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

`ifdef PIA_UART_UPCASE_EN
  assign rx_store = to_upper(rx_byte);
`else
  assign rx_store = rx_byte;
`endif

  assign kbd_rd     = bus.enable & ~bus.w_en & (bus.address == REG_KBD);
  assign dsp_wr     = bus.enable &  bus.w_en & (bus.address == REG_DSP);
  assign din_unused = bus.din[7];
  assign uart_cts   = kbd_ready;
  assign led        = kbd_data;

  always_comb begin
    bus.dout = 8'h00;
    case (bus.address)
      REG_KBD:   bus.dout = {1'b1, kbd_data[6:0]};
      REG_KBDCR: bus.dout = {kbd_ready, 7'b0};
      REG_DSP:   bus.dout = {tx_busy, 7'b0};
      default:   bus.dout = 8'h00;
    endcase
  end

  // A byte landing in the same cycle as a KBD read keeps kbd_ready set.
  always_ff @(posedge clk25) begin
    if (reset) begin
      kbd_data  <= '0;
      kbd_ready <= 1'b0;
    end else if (rx_valid) begin
      kbd_data  <= rx_store;
      kbd_ready <= 1'b1;
    end else if (kbd_rd) begin
      kbd_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_busy  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          if (dsp_wr) begin
            tx_shift <= {1'b0, bus.din[6:0]};
            tx_busy  <= 1'b1;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt   <= '0;
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == CW'(DIV - 1)) begin
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pia_uart.sv
// Scoreboard bench for pia_uart: bus reads and transmitted frames are checked
// by monitors against expectations queued by the directed stimulus.
module tb_pia_uart;
  localparam int unsigned DIV  = 217;
  localparam int unsigned HALF = DIV / 2;

  logic       clk25 = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       uart_tx;
  logic       uart_cts;
  logic [7:0] led;
  logic       rx_abort;

  pia_uart_if bus();

  pia_uart #(.CLK_FREQ(25000000), .BAUD(115200)) dut (
    .clk25    (clk25),
    .reset    (reset),
    .bus      (bus),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .uart_cts (uart_cts),
    .led      (led)
  );

  always #20 clk25 = ~clk25;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic bus_read(input string name, input logic [1:0] addr, input logic [7:0] exp);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    rd_q.push_back(e);
    bus.enable  = 1'b1;
    bus.w_en    = 1'b0;
    bus.address = addr;
    tick(1);
    bus.enable  = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
    bus.enable  = 1'b1;
    bus.w_en    = 1'b1;
    bus.address = addr;
    bus.din     = data;
    tick(1);
    bus.enable  = 1'b0;
    bus.w_en    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int unsigned i = 0; i < 10; i++) begin
      uart_rx = f[i];
      for (int unsigned k = 0; k < DIV; k++) begin
        if (rx_abort) begin
          uart_rx = 1'b1;
          return;
        end
        tick(1);
      end
    end
    uart_rx = 1'b1;
    tick(4);
  endtask

  // Read monitor: dout is compared in every read cycle, away from the edge.
  always @(negedge clk25) begin
    if (bus.enable === 1'b1 && bus.w_en === 1'b0) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check(e.name, {24'd0, bus.dout}, {24'd0, e.exp});
      end
    end
  end

  // Serial line monitor: decodes frames on uart_tx, abandons them on reset.
  initial begin : tx_monitor
    int unsigned low_run;
    int unsigned idx;
    bit          in_start;
    bit          aborted;
    logic [7:0]  d;
    logic        stop_b;
    logic [7:0]  e;
    forever begin
      @(negedge clk25);
      if (reset !== 1'b0 || uart_tx !== 1'b0) continue;
      low_run  = 1;
      in_start = 1'b1;
      aborted  = 1'b0;
      d        = '0;
      stop_b   = 1'b0;
      for (int unsigned n = 1; n <= HALF + 9 * DIV; n++) begin
        @(negedge clk25);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        if (in_start) begin
          if (uart_tx == 1'b0) low_run++;
          else in_start = 1'b0;
        end
        if (n >= HALF + DIV && (n - HALF) % DIV == 0) begin
          idx = (n - HALF) / DIV;
          if (idx <= 8) d[idx-1] = uart_tx;
          else stop_b = uart_tx;
        end
      end
      if (!aborted) begin
        check("tx_stop_bit", {31'd0, stop_b}, 32'd1);
        if (tx_q.size() == 0) begin
          check("tx_unexpected_frame", {24'd0, d}, 32'hFFFF);
        end else begin
          e = tx_q.pop_front();
          check("tx_frame", {24'd0, d}, {24'd0, e});
        end
        if (d[0]) check("tx_start_len", low_run, DIV);
      end
    end
  end

  initial begin : watchdog
    #(40 * 200000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset       = 1'b1;
    uart_rx     = 1'b1;
    rx_abort    = 1'b0;
    bus.enable  = 1'b0;
    bus.w_en    = 1'b0;
    bus.address = 2'd0;
    bus.din     = 8'h00;
    tick(5);
    reset = 1'b0;

    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_uart_cts", {31'd0, uart_cts}, 32'd0);
    check("rst_led", {24'd0, led}, 32'h00);
    bus_read("rst_kbd", 2'd0, 8'h80);
    bus_read("rst_kbdcr", 2'd1, 8'h00);
    bus_read("rst_dsp", 2'd2, 8'h00);
    bus_read("rst_dspcr", 2'd3, 8'h00);

    // Basic receive and KBD read clearing the ready flag
    send_byte(8'h41, 1'b1);
    check("rx41_cts", {31'd0, uart_cts}, 32'd1);
    check("rx41_led", {24'd0, led}, 32'h41);
    bus_read("rx41_kbdcr", 2'd1, 8'h80);
    bus_read("rx41_kbd", 2'd0, 8'hC1);
    bus_read("rx41_kbdcr_after", 2'd1, 8'h00);
    check("rx41_cts_after", {31'd0, uart_cts}, 32'd0);

    // Lower-case byte; ignored writes must not disturb state
    send_byte(8'h61, 1'b1);
    bus_write(2'd0, 8'h00);
    bus_write(2'd1, 8'h00);
    bus_write(2'd3, 8'hFF);
    bus_read("wr_ign_kbdcr", 2'd1, 8'h80);
    bus_read("wr_ign_dspcr", 2'd3, 8'h00);
`ifdef PIA_UART_UPCASE_EN
    bus_read("rx61_kbd", 2'd0, 8'hC1);
    check("rx61_led", {24'd0, led}, 32'h41);
`else
    bus_read("rx61_kbd", 2'd0, 8'hE1);
    check("rx61_led", {24'd0, led}, 32'h61);
`endif

    // Overrun: second byte overwrites, ready stays set
    send_byte(8'h35, 1'b1);
    send_byte(8'h36, 1'b1);
    bus_read("ovr_kbdcr", 2'd1, 8'h80);
    bus_read("ovr_kbd", 2'd0, 8'hB6);
    check("ovr_led", {24'd0, led}, 32'h36);

    // Framing error then a short low glitch: nothing accepted
    send_byte(8'h35, 1'b0);
    uart_rx = 1'b0;
    tick(50);
    uart_rx = 1'b1;
    tick(300);
    bus_read("ferr_kbdcr", 2'd1, 8'h00);
    check("ferr_led", {24'd0, led}, 32'h36);

    // Transmit 8'h8D: bit 7 dropped, busy exactly 10 bit periods
    tx_q.push_back(8'h0D);
    bus_write(2'd2, 8'h8D);
    bus_read("tx0d_busy", 2'd2, 8'h80);
    tick(2168);
    bus_read("tx0d_busy_last", 2'd2, 8'h80);
    bus_read("tx0d_done", 2'd2, 8'h00);
    tick(10);

    // Second write while busy is dropped
    tx_q.push_back(8'h41);
    bus_write(2'd2, 8'hC1);
    bus_write(2'd2, 8'hC2);
    bus_read("txbusy_dsp", 2'd2, 8'h80);
    tick(2 * 2170 + 200);
    check("txbusy_queue_left", tx_q.size(), 32'd0);
    bus_read("txbusy_dsp_done", 2'd2, 8'h00);

    // Reset during TX data bit 3 (0x55 -> bit 3 is low) with RX mid-frame
    bus_write(2'd2, 8'h55);
    fork
      send_byte(8'h5A, 1'b1);
      begin
        tick(967);
        check("midrst_tx_low", {31'd0, uart_tx}, 32'd0);
        reset = 1'b1;
        tick(1);
        check("midrst_tx_high", {31'd0, uart_tx}, 32'd1);
        reset    = 1'b0;
        rx_abort = 1'b1;
      end
    join
    rx_abort = 1'b0;
    tick(3 * DIV);
    bus_read("midrst_dsp", 2'd2, 8'h00);
    bus_read("midrst_kbdcr", 2'd1, 8'h00);
    check("midrst_led", {24'd0, led}, 32'h00);
    send_byte(8'h5A, 1'b1);
    bus_read("postrst_kbd", 2'd0, 8'hDA);
    check("postrst_led", {24'd0, led}, 32'h5A);
    tx_q.push_back(8'h33);
    bus_write(2'd2, 8'h33);
    tick(2300);
    bus_read("postrst_dsp", 2'd2, 8'h00);

    tick(5);
    check("end_tx_queue", tx_q.size(), 32'd0);
    check("end_rd_queue", rd_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pia_uart.md
PIA_UART -- requirements
Module: pia_uart

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; bit period DIV = CLK_FREQ/BAUD, integer-truncated (217 at defaults).
REQ-003 SHALL have ports (one clock; reset is synchronous and active-high):
 clk25  in  1  master clock, all state on rising edge
 reset  in  1  synchronous, active-high
 enable  in  1  bus access strobe, one clk25 cycle per CPU cycle (chip-select AND CPU clock enable)
 address  in  2  register select
 w_en  in  1  1 = write, 0 = read; acted on only with enable
 din  in  8  write data
 dout  out  8  read data
 uart_rx  in  1  serial in, idle high, asynchronous
 uart_tx  out  1  serial out, idle high
 uart_cts  out  1  flow control, 1 = receive holding full, host must pause
 led  out  8  last accepted received byte

Function
REQ-004 SHALL present an Apple-1 PIA register map: 0=KBD, 1=KBDCR, 2=DSP, 3=DSPCR.
REQ-005 dout SHALL be combinational on address: KBD={1,kbd_data[6:0]}; KBDCR={kbd_ready,7'b0}; DSP={tx_busy,7'b0}; DSPCR=8'h00.
REQ-006 Read of KBD (enable & !w_en & address==0) SHALL clear kbd_ready on the next clock edge; reads of other registers SHALL have no side effects.
REQ-007 Write to DSP (enable & w_en & address==2) with tx_busy==0 SHALL latch {1'b0,din[6:0]} and set tx_busy on the next edge; write while tx_busy==1 SHALL be ignored.
REQ-008 Writes to KBD, KBDCR, DSPCR SHALL be ignored.
REQ-009 TX SHALL send 8N1, LSB first, each bit exactly DIV clocks; states IDLE->START->DATA(8)->STOP->IDLE; tx_busy clears on the edge the stop bit ends.
REQ-010 uart_rx SHALL pass a 2-flop synchronizer before use.
REQ-011 RX states IDLE->START->DATA->STOP: falling edge in IDLE enters START; START re-sampled at DIV/2, return to IDLE if high (glitch); data sampled at DIV/2 + n*DIV.
REQ-012 Stop-bit sample 0 SHALL discard the byte (framing error), no flag change; stop-bit sample 1 SHALL load kbd_data and led, and set kbd_ready.
REQ-013 A byte completing while kbd_ready==1 SHALL overwrite kbd_data; kbd_ready stays 1.
REQ-014 Byte completion and KBD read in the same cycle: new byte wins, kbd_ready stays 1.
REQ-015 uart_cts SHALL equal kbd_ready.
REQ-016 RX and TX SHALL run fully concurrently and independently of enable.

Reset
REQ-017 On reset: uart_tx=1, uart_cts=0, led=8'h00, kbd_data=8'h00, kbd_ready=0, tx_busy=0, both FSMs IDLE, bit/baud counters 0; synchronizer flops=1.
REQ-018 Reset mid-frame SHALL abort both frames immediately; a partial RX byte is discarded, uart_tx returns high the next cycle.

Configuration
REQ-019 Macro PIA_UART_UPCASE_EN defined: accepted bytes 8'h61..8'h7A SHALL be stored as byte-8'h20 (kbd_data and led); undefined: bytes stored unchanged.

Structure
REQ-020 Register offsets (KBD/KBDCR/DSP/DSPCR) and FSM state encodings SHALL live in a shared package/include, pia_uart_pkg.
REQ-021 Receiver (synchronizer, RX FSM, counters) SHALL be sub-module pia_uart_rx with byte/valid output; TX and register decode stay in pia_uart.

Verification
REQ-022 Host sends 8'h41 at 115200 -> kbd_ready=1, uart_cts=1, KBDCR read 8'h80, KBD read 8'hC1, KBDCR read afterwards 8'h00.
REQ-023 Write DSP 8'h8D -> DSP read 8'h80 at once; uart_tx shows 8'h0D frame, 217 clocks/bit; DSP read 8'h00 after 2170 clocks.
REQ-024 Write DSP 8'hC1 then 8'hC2 while busy -> only 8'h41 transmitted.
REQ-025 Frame 8'h35 with stop bit 0, and a 50-clock low glitch -> kbd_ready stays 0, led unchanged.
REQ-026 Send 8'h61: with PIA_UART_UPCASE_EN KBD reads 8'hC1, led=8'h41; without, KBD reads 8'hE1, led=8'h61.
REQ-027 Reset asserted at TX data bit 3 and mid-RX -> uart_tx=1 next cycle, DSP reads 8'h00, kbd_ready=0; next full frame received correctly.
